// File: rtl/arb_pkg.sv
// Shared arbitration package: requester count, index width and FSM state
// encoding. Also imported by the 5-to-32 decoder wrapper, so keep it
// free of arbiter-internal details.
package arb_pkg;
  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter32_if.sv
// Request/grant bus between the requesters and the arbiter.
//   req       : level request vector, bit i = requester i
//   gnt_idx   : registered winner index (drives the decoder)
//   gnt_valid : gnt_idx holds a winner
//   gnt_ready : downstream accepts gnt_idx this cycle
//   gnt_lock  : keep ptr on accept (only with RR_ARB_LOCK_EN)
//   ptr       : current highest-priority index, visibility only
// slave modport = arbiter side, master modport = requester/consumer side.
interface rr_arbiter32_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_ready;
`ifdef RR_ARB_LOCK_EN
  logic             gnt_lock;
`endif
  logic [IDX_W-1:0] ptr;

  modport slave (
    input  req,
    input  gnt_ready,
`ifdef RR_ARB_LOCK_EN
    input  gnt_lock,
`endif
    output gnt_idx,
    output gnt_valid,
    output ptr
  );

  modport master (
    output req,
    output gnt_ready,
`ifdef RR_ARB_LOCK_EN
    output gnt_lock,
`endif
    input  gnt_idx,
    input  gnt_valid,
    input  ptr
  );
endinterface

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: rotate req so that bit ptr lands at
// position 0, take the lowest set bit, then add ptr back to undo the
// rotation. Index arithmetic is IDX_W wide so wrap 31->0 is free.
//   req : request vector
//   ptr : search start (highest priority)
//   idx : first set bit at or above ptr, wrapping
//   any : at least one request set
module rr_pick32
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  for (genvar i = 0; i < N_REQ; i++) begin : g_rot
    assign rot[i] = req[IDX_W'(i) + ptr];
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
  end

  assign idx = ptr + off;
  assign any = |req;
endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter, 32 requesters, registered winner index with a
// valid/ready handshake. Holds only the FSM and registers; the search is
// done in rr_pick32.
//   clk   : clock, rising edge
//   rst_n : async active-low reset
//   bus   : rr_arbiter32_if.slave (req, gnt_idx, gnt_valid, gnt_ready, ptr,
//           gnt_lock when RR_ARB_LOCK_EN is defined)
// Optional feature macro: RR_ARB_LOCK_EN (lock keeps ptr and re-grants the
// same index while it is still requesting).
module rr_arbiter32
  import arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter32_if.slave  bus
);
  arb_state_t       state;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_valid_q;
  logic [IDX_W-1:0] ptr_q;

  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             lock;

`ifdef RR_ARB_LOCK_EN
  assign lock = bus.gnt_lock;
`else
  assign lock = 1'b0;
`endif

  // ptr after an accept; the just-accepted index becomes lowest priority.
  // Search start for re-arbitration: in IDLE use the held ptr; on accept
  // use the new ptr, except a lock with the owner still requesting starts
  // at the owner so it wins again.
  always_comb begin
    nxt_ptr  = lock ? ptr_q : gnt_idx_q + 1'b1;
    pick_ptr = ptr_q;
    if (state == GRANT)
      pick_ptr = (lock && bus.req[gnt_idx_q]) ? gnt_idx_q : nxt_ptr;
  end

  rr_pick32 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // winner held, no retraction, until accepted
          if (bus.gnt_ready) begin
            ptr_q <= nxt_ptr;
            if (pick_any) begin
              gnt_idx_q <= pick_idx;
            end else begin
              gnt_valid_q <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.ptr       = ptr_q;
endmodule
